// File: rtl/program_loader_if.sv
// Bus bundle for program_loader: the incoming image word stream plus the
// dedicated RAM write port driven towards the CPU core's memory.
interface program_loader_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 5
);
    logic                     inValid;
    logic [DATA_WIDTH-1:0]    inData;
    logic                     inReady;
    logic                     memWe;
    logic [ADDRESS_WIDTH-1:0] memAddr;
    logic [DATA_WIDTH-1:0]    memWdata;

    // Environment side: produces the stream, observes the RAM writes.
    modport master (
        output inValid,
        output inData,
        input  inReady,
        input  memWe,
        input  memAddr,
        input  memWdata
    );

    // Loader side: consumes the stream, drives the RAM writes.
    modport slave (
        input  inValid,
        input  inData,
        output inReady,
        output memWe,
        output memAddr,
        output memWdata
    );
endinterface

// File: rtl/program_loader.sv
// Boot/run sequencer: streams a program image into the CPU RAM while holding the
// core in reset, then releases it and times its run until halt or timeout.
module program_loader #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDRESS_WIDTH  = 5,
    parameter int CYCLE_WIDTH    = 16,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_start,
    input  logic [ADDRESS_WIDTH:0] i_loadLen,
    program_loader_if.slave        bus,
    output logic                   o_cpuNRst,
    input  logic                   i_cpuHalt,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_timeout,
    output logic [CYCLE_WIDTH-1:0] o_cycleCount
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOAD      = 3'd1;
    localparam logic [2:0] S_FLUSH     = 3'd2;
    localparam logic [2:0] S_RUN       = 3'd3;
    localparam logic [2:0] S_HALTED    = 3'd4;
    localparam logic [2:0] S_TIMED_OUT = 3'd5;

    localparam int                     DEPTH_INT     = 1 << ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH:0] DEPTH         = DEPTH_INT[ADDRESS_WIDTH:0];
    localparam logic [ADDRESS_WIDTH:0] PTR_ONE       = {{ADDRESS_WIDTH{1'b0}}, 1'b1};
    localparam logic [CYCLE_WIDTH-1:0] CNT_ONE       = {{(CYCLE_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CYCLE_WIDTH-1:0] TIMEOUT_LIMIT = TIMEOUT_CYCLES[CYCLE_WIDTH-1:0];

    logic [2:0]               r_state;
    logic [ADDRESS_WIDTH:0]   r_len;
    logic [ADDRESS_WIDTH:0]   r_ptr;
    logic                     r_memWe;
    logic [ADDRESS_WIDTH-1:0] r_memAddr;
    logic [DATA_WIDTH-1:0]    r_memWdata;
    logic                     r_cpuNRst;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_timeout;
    logic [CYCLE_WIDTH-1:0]   r_cycleCount;

    logic                     w_inReady;
    logic                     w_accept;
    logic                     w_lastWord;
    logic [ADDRESS_WIDTH:0]   w_clampedLen;
    logic [CYCLE_WIDTH-1:0]   w_nextCount;

    // Clamping the length to the RAM depth is what keeps the write pointer from wrapping.
    assign w_clampedLen = (i_loadLen > DEPTH) ? DEPTH : i_loadLen;
    assign w_inReady    = (r_state == S_LOAD);
    assign w_accept     = bus.inValid & w_inReady;
    assign w_lastWord   = ((r_ptr + PTR_ONE) == r_len);
    assign w_nextCount  = r_cycleCount + CNT_ONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_len        <= '0;
            r_ptr        <= '0;
            r_memWe      <= 1'b0;
            r_memAddr    <= '0;
            r_memWdata   <= '0;
            r_cpuNRst    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_timeout    <= 1'b0;
            r_cycleCount <= '0;
        end else begin
            r_memWe <= 1'b0;
            case (r_state)
                S_IDLE, S_HALTED, S_TIMED_OUT: begin
                    if (i_start) begin
                        r_len        <= w_clampedLen;
                        r_ptr        <= '0;
                        r_done       <= 1'b0;
                        r_timeout    <= 1'b0;
                        r_cycleCount <= '0;
                        r_cpuNRst    <= 1'b0;
                        r_busy       <= 1'b1;
                        r_state      <= (w_clampedLen == '0) ? S_FLUSH : S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        r_memWe    <= 1'b1;
                        r_memAddr  <= r_ptr[ADDRESS_WIDTH-1:0];
                        r_memWdata <= bus.inData;
                        r_ptr      <= r_ptr + PTR_ONE;
                        if (w_lastWord) begin
                            r_state <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    r_state   <= S_RUN;
                    r_cpuNRst <= 1'b1;
                end
                S_RUN: begin
                    // A sampled halt wins over a limit reached on the same edge.
                    if (i_cpuHalt) begin
                        r_state <= S_HALTED;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cycleCount <= w_nextCount;
                        if (w_nextCount == TIMEOUT_LIMIT) begin
                            r_state   <= S_TIMED_OUT;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                            r_timeout <= 1'b1;
                            r_cpuNRst <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.inReady  = w_inReady;
    assign bus.memWe    = r_memWe;
    assign bus.memAddr  = r_memAddr;
    assign bus.memWdata = r_memWdata;
    assign o_cpuNRst    = r_cpuNRst;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_timeout    = r_timeout;
    assign o_cycleCount = r_cycleCount;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: a transaction-level model of the
// load/run sequence is compared against the DUT every cycle, plus directed literals.
module tb_program_loader;

    localparam int DEPTH   = 32;
    localparam int TIMEOUT = 1000;

    logic        clk;
    logic        rst;
    logic        tbStart;
    logic [5:0]  tbLoadLen;
    logic        tbHalt;
    logic        o_cpuNRst;
    logic        o_busy;
    logic        o_done;
    logic        o_timeout;
    logic [15:0] o_cycleCount;

    int errors = 0;
    int checks = 0;

    program_loader_if #(.DATA_WIDTH(8), .ADDRESS_WIDTH(5)) bus ();

    program_loader #(
        .DATA_WIDTH(8),
        .ADDRESS_WIDTH(5),
        .CYCLE_WIDTH(16),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_start(tbStart),
        .i_loadLen(tbLoadLen),
        .bus(bus),
        .o_cpuNRst(o_cpuNRst),
        .i_cpuHalt(tbHalt),
        .o_busy(o_busy),
        .o_done(o_done),
        .o_timeout(o_timeout),
        .o_cycleCount(o_cycleCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Model: phase flags plus the expected register values of the sequencer.
    bit mLoading, mFlushing, mRunning, mFinished, mTimedOut, mWe, mNRst;
    int mLen, mIdx, mCount, mAddr, mData;
    int logAddr[$];
    int logData[$];

    // Inputs change 1 time unit after the falling edge, so at the falling edge they
    // still hold what the preceding rising edge sampled.
    task automatic modelStep();
        int lenReq;
        if (rst) begin
            mLoading = 0; mFlushing = 0; mRunning = 0; mFinished = 0; mTimedOut = 0;
            mWe = 0; mNRst = 0; mLen = 0; mIdx = 0; mCount = 0; mAddr = 0; mData = 0;
        end else begin
            mWe = 0;
            if (!(mLoading || mFlushing || mRunning)) begin
                if (tbStart) begin
                    lenReq = int'(tbLoadLen);
                    mLen = (lenReq > DEPTH) ? DEPTH : lenReq;
                    mIdx = 0; mCount = 0; mFinished = 0; mTimedOut = 0; mNRst = 0;
                    if (mLen == 0) mFlushing = 1;
                    else mLoading = 1;
                end
            end else if (mLoading) begin
                if (bus.inValid) begin
                    mWe = 1; mAddr = mIdx; mData = int'(bus.inData);
                    mIdx++;
                    if (mIdx == mLen) begin
                        mLoading = 0; mFlushing = 1;
                    end
                end
            end else if (mFlushing) begin
                mFlushing = 0; mRunning = 1; mNRst = 1;
            end else begin
                if (tbHalt) begin
                    mRunning = 0; mFinished = 1;
                end else begin
                    mCount++;
                    if (mCount == TIMEOUT) begin
                        mRunning = 0; mFinished = 1; mTimedOut = 1; mNRst = 0;
                    end
                end
            end
        end
    endtask

    always @(negedge clk) begin
        modelStep();
        checkOutput("in_ready",    32'(bus.inReady), 32'(mLoading));
        checkOutput("mem_we",      32'(bus.memWe),   32'(mWe));
        checkOutput("mem_addr",    32'(bus.memAddr), mAddr);
        checkOutput("mem_wdata",   32'(bus.memWdata), mData);
        checkOutput("cpu_n_rst",   32'(o_cpuNRst),   32'(mNRst));
        checkOutput("busy",        32'(o_busy),      32'(mLoading || mFlushing || mRunning));
        checkOutput("done",        32'(o_done),      32'(mFinished));
        checkOutput("timeout",     32'(o_timeout),   32'(mTimedOut));
        checkOutput("cycle_count", 32'(o_cycleCount), mCount);
        if (bus.memWe === 1'b1) begin
            logAddr.push_back(int'(bus.memAddr));
            logData.push_back(int'(bus.memWdata));
        end
    end

    task automatic applyStimulus(input bit s, input int len, input bit v, input logic [7:0] d, input bit h);
        tbStart     = s;
        tbLoadLen   = len[5:0];
        bus.inValid = v;
        bus.inData  = d;
        tbHalt      = h;
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 8'h00, 0);
    endtask

    initial begin
        bit seen;
        rst = 1'b1;
        tbStart = 0; tbLoadLen = '0; tbHalt = 0;
        bus.inValid = 0; bus.inData = '0;

        // T1: reset
        idle(2);
        checkOutput("t1_busy", 32'(o_busy), 0);
        checkOutput("t1_nrst", 32'(o_cpuNRst), 0);
        checkOutput("t1_ready", 32'(bus.inReady), 0);
        checkOutput("t1_we", 32'(bus.memWe), 0);
        checkOutput("t1_done", 32'(o_done), 0);
        checkOutput("t1_count", 32'(o_cycleCount), 0);
        rst = 1'b0;

        // T2: three back-to-back words
        applyStimulus(1, 3, 0, 8'h00, 0);
        checkOutput("t2_ready", 32'(bus.inReady), 1);
        applyStimulus(0, 0, 1, 8'hA0, 0);
        applyStimulus(0, 0, 1, 8'hA1, 0);
        applyStimulus(0, 0, 1, 8'hA2, 0);
        checkOutput("t2_last_addr", 32'(bus.memAddr), 2);
        checkOutput("t2_last_data", 32'(bus.memWdata), 32'hA2);
        checkOutput("t2_nrst_held", 32'(o_cpuNRst), 0);
        applyStimulus(0, 0, 0, 8'h00, 0);
        checkOutput("t2_release", 32'(o_cpuNRst), 1);
        applyStimulus(0, 0, 0, 8'h00, 1);
        idle(1);
        checkOutput("t2_nwrites", logAddr.size(), 3);
        if (logAddr.size() == 3) begin
            checkOutput("t2_addr0", logAddr[0], 0);
            checkOutput("t2_data0", logData[0], 32'hA0);
            checkOutput("t2_data1", logData[1], 32'hA1);
            checkOutput("t2_addr2", logAddr[2], 2);
        end
        logAddr.delete(); logData.delete();

        // T3: oversize length with gaps, clamped to depth
        applyStimulus(1, 40, 0, 8'h00, 0);
        for (int i = 0; i < 48; i++) applyStimulus(0, 0, (i % 3) != 2, 8'(8'h40 + i), 0);
        idle(3);
        applyStimulus(0, 0, 0, 8'h00, 1);
        idle(1);
        checkOutput("t3_nwrites", logAddr.size(), 32);
        for (int k = 0; k < logAddr.size(); k++) checkOutput("t3_addr_seq", logAddr[k], k);
        if (logData.size() == 32) begin
            checkOutput("t3_data_first", logData[0], 32'h40);
            checkOutput("t3_data_last", logData[31], 32'h6E);
        end
        logAddr.delete(); logData.delete();

        // T4: halt after 17 run cycles, then restart
        applyStimulus(1, 1, 0, 8'h00, 0);
        applyStimulus(0, 0, 1, 8'h5A, 0);
        applyStimulus(0, 0, 0, 8'h00, 0);
        checkOutput("t4_release", 32'(o_cpuNRst), 1);
        idle(17);
        applyStimulus(0, 0, 0, 8'h00, 1);
        checkOutput("t4_count", 32'(o_cycleCount), 17);
        checkOutput("t4_done", 32'(o_done), 1);
        checkOutput("t4_timeout", 32'(o_timeout), 0);
        idle(1);
        checkOutput("t4_nrst_kept", 32'(o_cpuNRst), 1);
        applyStimulus(1, 2, 0, 8'h00, 0);
        checkOutput("t4_restart_busy", 32'(o_busy), 1);
        checkOutput("t4_restart_done", 32'(o_done), 0);
        checkOutput("t4_restart_nrst", 32'(o_cpuNRst), 0);
        applyStimulus(0, 0, 1, 8'h11, 0);
        applyStimulus(0, 0, 1, 8'h22, 0);
        applyStimulus(0, 0, 0, 8'h00, 0);

        // T5: no halt -> timeout at the limit
        seen = 0;
        for (int k = 0; k < 1100 && !seen; k++) begin
            applyStimulus(0, 0, 0, 8'h00, 0);
            if (o_timeout === 1'b1) seen = 1;
        end
        checkOutput("t5_timeout_reached", 32'(seen), 1);
        checkOutput("t5_count", 32'(o_cycleCount), 1000);
        checkOutput("t5_done", 32'(o_done), 1);
        checkOutput("t5_nrst", 32'(o_cpuNRst), 0);
        logAddr.delete(); logData.delete();

        // T5b/T6: zero-length run, halt on the limit edge
        applyStimulus(1, 0, 0, 8'h00, 0);
        applyStimulus(0, 0, 0, 8'h00, 0);
        checkOutput("t6_len0_release", 32'(o_cpuNRst), 1);
        idle(999);
        checkOutput("t5_count_999", 32'(o_cycleCount), 999);
        applyStimulus(0, 0, 0, 8'h00, 1);
        checkOutput("t5_tie_timeout", 32'(o_timeout), 0);
        checkOutput("t5_tie_done", 32'(o_done), 1);
        checkOutput("t5_tie_count", 32'(o_cycleCount), 999);
        checkOutput("t6_len0_nwrites", logAddr.size(), 0);

        // T6: start ignored while busy, reset mid-load
        applyStimulus(1, 5, 0, 8'h00, 0);
        applyStimulus(0, 0, 1, 8'h01, 0);
        applyStimulus(0, 0, 1, 8'h02, 0);
        applyStimulus(1, 7, 0, 8'h00, 0);
        checkOutput("t6_busy_held", 32'(o_busy), 1);
        rst = 1'b1;
        applyStimulus(0, 0, 0, 8'h00, 0);
        checkOutput("t6_rst_busy", 32'(o_busy), 0);
        checkOutput("t6_rst_ready", 32'(bus.inReady), 0);
        checkOutput("t6_rst_we", 32'(bus.memWe), 0);
        rst = 1'b0;
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
